// File: rtl/stdp_pkg.sv
// Shared types and defaults for the STDP learning controller.
package stdp_pkg;

  localparam int unsigned DEF_W_BITS = 8;
  localparam int unsigned DEF_T_BITS = 4;
  localparam int unsigned DEF_W_INIT = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRE_SEEN  = 2'd1,
    POST_SEEN = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Largest timing-counter value: also the last cycle of the pairing window
  function automatic int unsigned tmax(input int unsigned t_bits);
    return (32'd1 << t_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/stdp_sat_addsub.sv
// Saturating weight adjust; the subtract path exists only with STDP_LTD_EN.
module stdp_sat_addsub #(
  parameter int unsigned W_BITS = 8,
  parameter int unsigned D_BITS = 5
) (
  input  logic [W_BITS-1:0] weight,
  input  logic [D_BITS-1:0] delta,
  input  logic              dir,
  output logic [W_BITS-1:0] clamped_c
);

  localparam int unsigned S_BITS = ((W_BITS > D_BITS) ? W_BITS : D_BITS) + 1;
  localparam logic [S_BITS-1:0] WMAX = S_BITS'({W_BITS{1'b1}});

  logic [S_BITS-1:0] w_ext;
  logic [S_BITS-1:0] d_ext;
  logic [S_BITS-1:0] sum;

  assign w_ext = S_BITS'(weight);
  assign d_ext = S_BITS'(delta);
  assign sum   = w_ext + d_ext;

  always_comb begin
    clamped_c = weight;
    if (dir) clamped_c = (sum > WMAX) ? {W_BITS{1'b1}} : W_BITS'(sum);
`ifdef STDP_LTD_EN
    else clamped_c = (d_ext > w_ext) ? '0 : W_BITS'(w_ext - d_ext);
`endif
  end

endmodule

// File: rtl/stdp_ctrl.sv
// Pair-based STDP weight controller. Depression (post-before-pre) is built
// only when STDP_LTD_EN is defined; otherwise the weight can only grow.
module stdp_ctrl
  import stdp_pkg::*;
#(
  parameter int unsigned W_BITS = DEF_W_BITS,
  parameter int unsigned T_BITS = DEF_T_BITS,
  parameter int unsigned W_INIT = DEF_W_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pre_spike,
  input  logic              post_spike,
  output logic [W_BITS-1:0] weight,
  output logic              update_w_flag,
  output logic [T_BITS-1:0] time_diff,
  output logic              ltp
);

  localparam int unsigned D_BITS = T_BITS + 1;
  localparam logic [T_BITS-1:0] TMAX = T_BITS'(tmax(T_BITS));

  state_t            state_q, state_d;
  logic [T_BITS-1:0] cnt_q, cnt_d;
  logic [T_BITS-1:0] dt_q, dt_d;
  logic              dir_q, dir_d;
  logic              upd_c;
  logic [D_BITS-1:0] delta_c;
  logic [W_BITS-1:0] clamped_c;

  // Closer pairings give larger steps: dt=1 -> TMAX, dt=TMAX -> 1
  assign delta_c = D_BITS'(TMAX) + D_BITS'(1) - D_BITS'(dt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dt_d    = dt_q;
    dir_d   = dir_q;
    upd_c   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (pre_spike && !post_spike) begin
            state_d = PRE_SEEN;
            cnt_d   = T_BITS'(1);
          end
`ifdef STDP_LTD_EN
          else if (post_spike && !pre_spike) begin
            state_d = POST_SEEN;
            cnt_d   = T_BITS'(1);
          end
`endif
        end
        PRE_SEEN: begin
          if (post_spike) begin
            state_d = UPDATE;
            dt_d    = cnt_q;
            dir_d   = 1'b1;
            cnt_d   = '0;
          end else if (pre_spike) begin
            cnt_d = T_BITS'(1);
          end else if (cnt_q == TMAX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + T_BITS'(1);
          end
        end
`ifdef STDP_LTD_EN
        POST_SEEN: begin
          if (pre_spike) begin
            state_d = UPDATE;
            dt_d    = cnt_q;
            dir_d   = 1'b0;
            cnt_d   = '0;
          end else if (post_spike) begin
            cnt_d = T_BITS'(1);
          end else if (cnt_q == TMAX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + T_BITS'(1);
          end
        end
`endif
        UPDATE: begin
          state_d = IDLE;
          cnt_d   = '0;
          upd_c   = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dt_q          <= '0;
      dir_q         <= 1'b0;
      weight        <= W_BITS'(W_INIT);
      update_w_flag <= 1'b0;
      time_diff     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dt_q          <= dt_d;
      dir_q         <= dir_d;
      update_w_flag <= upd_c;
      if (upd_c) begin
        weight    <= clamped_c;
        time_diff <= dt_q;
      end
    end
  end

`ifdef STDP_LTD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ltp <= 1'b0;
    else if (upd_c) ltp <= dir_q;
  end
`else
  assign ltp = 1'b1;
`endif

  stdp_sat_addsub #(
    .W_BITS(W_BITS),
    .D_BITS(D_BITS)
  ) u_sat (
    .weight   (weight),
    .delta    (delta_c),
    .dir      (dir_q),
    .clamped_c(clamped_c)
  );

endmodule
